// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding, bus constants and a majority helper
// shared by the I2C target and its pin front end.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTRH,
        PTRH_ACK,
        PTRL,
        PTRL_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        WAIT_STOP
    } state_t;

    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;
    localparam logic I2C_RW_READ = 1'b1;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: pin synchronizers, optional majority filter
// (I2C_TARGET_GLITCH_FILTER_EN) and SCL edge / START / STOP detection.
module i2c_bus_sync
    import i2c_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic scl_pin,
    input  logic sda_pin,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_f;
    logic       sda_f;
    logic       scl_q;
    logic       sda_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_pin};
            sda_sync <= {sda_sync[0], sda_pin};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [2:0] scl_hist;
    logic [2:0] sda_hist;

    // A one-clock pulse occupies a single history slot and never wins the vote.
    always_ff @(posedge clock) begin
        if (reset) begin
            scl_hist <= 3'b111;
            sda_hist <= 3'b111;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[1:0], scl_sync[1]};
            sda_hist <= {sda_hist[1:0], sda_sync[1]};
            scl_f    <= maj3(scl_hist);
            sda_f    <= maj3(sda_hist);
        end
    end
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    assign sda_s     = sda_f;
    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C responder with 16-bit big-endian register pointer,
// auto-increment and byte register port. Filter: I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = 7'h29
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        SCL_in,
    input  logic        SDA_in,
    output logic        SDA_out,
    output logic        SDA_t,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [7:0]  reg_rdata,
    output logic        busy,
    output logic        error_out
);

    logic       scl_rise;
    logic       scl_fall;
    logic       sda_s;
    logic       start_det;
    logic       stop_det;
    state_t     state;
    state_t     after_ack;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] ptr_hi;
    logic [7:0] rx_byte;
    logic       rw;
    logic       inc_pend;
    logic       re_d;
    logic       sda_rel;
    logic       byte_end;
    logic       in_byte;

    i2c_bus_sync u_sync (
        .clock     (clock),
        .reset     (reset),
        .scl_pin   (SCL_in),
        .sda_pin   (SDA_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign rx_byte  = {shift[6:0], sda_s};
    assign byte_end = (bit_cnt == 4'd7);
    assign SDA_out  = sda_rel;
    assign SDA_t    = sda_rel;

    // The SCL rise leading into a STOP or repeated START counts as one bit.
    assign in_byte = (bit_cnt > 4'd1) &&
                     (state == PTRH || state == PTRL ||
                      state == WDATA || state == RDATA);

    always_comb begin
        after_ack = WDATA;
        if (state == ADDR_ACK) after_ack = PTRH;
        else if (state == PTRH_ACK) after_ack = PTRL;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            ptr_hi    <= '0;
            rw        <= 1'b0;
            inc_pend  <= 1'b0;
            re_d      <= 1'b0;
            sda_rel   <= 1'b1;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
            error_out <= 1'b0;
        end else begin
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            error_out <= 1'b0;
            inc_pend  <= 1'b0;
            re_d      <= reg_re;
            if (inc_pend || re_d) reg_addr <= reg_addr + 16'd1;
            if (re_d) shift <= reg_rdata;

            if (start_det) begin
                error_out <= in_byte;
                state     <= ADDR;
                bit_cnt   <= '0;
                sda_rel   <= 1'b1;
            end else if (stop_det) begin
                error_out <= in_byte;
                state     <= IDLE;
                bit_cnt   <= '0;
                sda_rel   <= 1'b1;
                busy      <= 1'b0;
            end else if (scl_rise) begin
                unique case (state)
                    ADDR: begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (byte_end) begin
                            if (rx_byte[7:1] == DEVICE_ADDR) begin
                                state <= ADDR_ACK;
                                busy  <= 1'b1;
                                rw    <= rx_byte[0];
                            end else begin
                                state <= WAIT_STOP;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    PTRH, PTRL, WDATA: begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (byte_end) begin
                            if (state == PTRH) begin
                                ptr_hi <= rx_byte;
                                state  <= PTRH_ACK;
                            end else if (state == PTRL) begin
                                reg_addr <= {ptr_hi, rx_byte};
                                state    <= PTRL_ACK;
                            end else begin
                                reg_wdata <= rx_byte;
                                reg_we    <= 1'b1;
                                inc_pend  <= 1'b1;
                                state     <= WDATA_ACK;
                            end
                        end
                    end
                    RDATA: begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (byte_end) state <= RDATA_ACK;
                    end
                    ADDR_ACK: begin
                        if (bit_cnt == 4'd9 && rw == I2C_RW_READ)
                            reg_re <= 1'b1;
                    end
                    RDATA_ACK: begin
                        if (bit_cnt == 4'd9) begin
                            if (sda_s == I2C_ACK) reg_re <= 1'b1;
                            else state <= WAIT_STOP;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                unique case (state)
                    ADDR_ACK, PTRH_ACK, PTRL_ACK, WDATA_ACK: begin
                        if (bit_cnt == 4'd8) begin
                            sda_rel <= I2C_ACK;
                            bit_cnt <= 4'd9;
                        end else begin
                            bit_cnt <= '0;
                            if (state == ADDR_ACK && rw == I2C_RW_READ) begin
                                state   <= RDATA;
                                sda_rel <= shift[7];
                            end else begin
                                state   <= after_ack;
                                sda_rel <= 1'b1;
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (bit_cnt == 4'd8) begin
                            sda_rel <= I2C_NACK;
                            bit_cnt <= 4'd9;
                        end else begin
                            state   <= RDATA;
                            sda_rel <= shift[7];
                            bit_cnt <= '0;
                        end
                    end
                    RDATA: begin
                        sda_rel <= shift[6];
                        shift   <= {shift[6:0], 1'b1};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed I2C master transactions against i2c_target
// with a register model that returns reg_addr[7:0].
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        SDA_out;
    logic        SDA_t;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [7:0]  reg_rdata;
    logic        busy;
    logic        error_out;
    wire         sda_bus = m_sda & (SDA_t | SDA_out);

    int total = 0;
    int bad = 0;
    int n_we = 0;
    int n_re = 0;
    int n_err = 0;
    int n_start = 0;
    int n_both = 0;
    int n_drive = 0;
    logic [23:0] we_log [$];

    i2c_target dut (
        .clock     (clock),
        .reset     (reset),
        .SCL_in    (m_scl),
        .SDA_in    (sda_bus),
        .SDA_out   (SDA_out),
        .SDA_t     (SDA_t),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .error_out (error_out)
    );

    always #5 clock = ~clock;

    always_ff @(posedge clock) begin
        if (reset) reg_rdata <= 8'h00;
        else if (reg_re) reg_rdata <= reg_addr[7:0];
    end

    always @(posedge clock) begin
        if (!reset) begin
            if (reg_we) begin
                n_we++;
                we_log.push_back({reg_addr, reg_wdata});
            end
            if (reg_re) n_re++;
            if (reg_we && reg_re) n_both++;
            if (error_out) n_err++;
            if (dut.u_sync.start_det) n_start++;
            if (!SDA_t) n_drive++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic wq(input int n = 1);
        repeat (n * Q) @(negedge clock);
    endtask

    task automatic i2c_start;
        m_sda = 1'b1; wq;
        m_scl = 1'b1; wq;
        m_sda = 1'b0; wq;
        m_scl = 1'b0; wq;
    endtask

    task automatic i2c_stop;
        m_sda = 1'b0; wq;
        m_scl = 1'b1; wq;
        m_sda = 1'b1; wq(2);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            m_sda = b[7 - i]; wq;
            m_scl = 1'b1; wq(2);
            m_scl = 1'b0; wq;
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        m_sda = 1'b1; wq;
        m_scl = 1'b1; wq;
        ack = sda_bus; wq;
        m_scl = 1'b0; wq;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        b = 8'h00;
        m_sda = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wq;
            m_scl = 1'b1; wq;
            b = {b[6:0], sda_bus}; wq;
            m_scl = 1'b0; wq;
        end
        m_sda = mack; wq;
        m_scl = 1'b1; wq(2);
        m_scl = 1'b0; wq;
        m_sda = 1'b1;
    endtask

    initial begin
        logic       ack;
        logic [4:0] acks;
        logic [7:0] b0, b1, b2;
        int         base_we, base_re, base_err, base_drv, base_st;
        int         exp_glitch;

        repeat (4) @(negedge clock);
        check("rst_ctl", {SDA_out, SDA_t, reg_we, reg_re, busy, error_out},
              6'b110000);
        check("rst_ptr", reg_addr, 16'h0000);
        check("rst_wdata", reg_wdata, 8'h00);
        reset = 1'b0;
        wq(2);

        // write pointer 0x010F then two data bytes
        base_we = n_we;
        i2c_start;
        write_byte(8'h52, ack); acks[0] = ack;
        check("t1_busy", busy, 1'b1);
        write_byte(8'h01, ack); acks[1] = ack;
        write_byte(8'h0F, ack); acks[2] = ack;
        write_byte(8'hA5, ack); acks[3] = ack;
        write_byte(8'h3C, ack); acks[4] = ack;
        i2c_stop;
        check("t1_acks", acks, 5'b00000);
        check("t1_nwe", n_we - base_we, 2);
        check("t1_we0", we_log[base_we], 24'h010FA5);
        check("t1_we1", we_log[base_we + 1], 24'h01103C);
        check("t1_ptr", reg_addr, 16'h0111);
        check("t1_idle", busy, 1'b0);

        // pointer 0x0000, STOP, then read three bytes
        i2c_start;
        write_byte(8'h52, ack);
        write_byte(8'h00, ack);
        write_byte(8'h00, ack);
        i2c_stop;
        base_re = n_re;
        i2c_start;
        write_byte(8'h53, ack);
        check("t2_aack", ack, 1'b0);
        read_byte(1'b0, b0);
        read_byte(1'b0, b1);
        read_byte(1'b1, b2);
        check("t2_data", {b0, b1, b2}, 24'h000102);
        check("t2_nre", n_re - base_re, 3);
        wq;
        check("t2_rel", SDA_t, 1'b1);
        i2c_stop;
        check("t2_ptr", reg_addr, 16'h0003);

        // foreign address 0x30
        base_we = n_we; base_re = n_re; base_drv = n_drive;
        i2c_start;
        write_byte(8'h60, ack);
        check("t3_nack", ack, 1'b1);
        check("t3_busy", busy, 1'b0);
        write_byte(8'h11, ack);
        i2c_stop;
        check("t3_drive", n_drive - base_drv, 0);
        check("t3_strb", (n_we - base_we) + (n_re - base_re), 0);

        // pointer wrap
        base_we = n_we;
        i2c_start;
        write_byte(8'h52, ack);
        write_byte(8'hFF, ack);
        write_byte(8'hFF, ack);
        write_byte(8'h11, ack);
        write_byte(8'h22, ack);
        i2c_stop;
        check("t4_we0", we_log[base_we], 24'hFFFF11);
        check("t4_we1", we_log[base_we + 1], 24'h000022);
        check("t4_ptr", reg_addr, 16'h0001);
        check("t4_noerr", n_err, 0);

        // STOP after 4 data bits
        base_we = n_we; base_err = n_err;
        i2c_start;
        write_byte(8'h52, ack);
        write_byte(8'h00, ack);
        write_byte(8'h10, ack);
        send_bits(8'hC0, 4);
        i2c_stop;
        check("t5_err", n_err - base_err, 1);
        check("t5_nowe", n_we - base_we, 0);
        check("t5_state", 32'(dut.state), 32'(IDLE));

        // repeated START in the middle of a read of 0xFF
        i2c_start;
        write_byte(8'h52, ack);
        write_byte(8'h00, ack);
        write_byte(8'hFF, ack);
        i2c_stop;
        base_err = n_err;
        i2c_start;
        write_byte(8'h53, ack);
        m_sda = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wq;
            m_scl = 1'b1; wq(2);
            m_scl = 1'b0; wq;
        end
        m_sda = 1'b1; wq;
        m_scl = 1'b1; wq;
        m_sda = 1'b0; wq;
        check("t5_rs_state", 32'(dut.state), 32'(ADDR));
        check("t5_rs_err", n_err - base_err, 1);
        m_scl = 1'b0; wq;
        write_byte(8'h52, ack);
        check("t5_rs_ack", ack, 1'b0);
        i2c_stop;

        // one-clock SDA glitch while SCL is high
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        exp_glitch = 0;
`else
        exp_glitch = 1;
`endif
        base_st = n_start;
        @(negedge clock); m_sda = 1'b0;
        @(negedge clock); m_sda = 1'b1;
        wq(2);
        check("t6_glitch", n_start - base_st, exp_glitch);
        check("t6_state", 32'(dut.state), 32'(IDLE));

        // reset while the ACK is being driven
        i2c_start;
        send_bits(8'h52, 8);
        m_sda = 1'b1; wq;
        check("t7_ackdrv", SDA_t, 1'b0);
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        check("t7_rel", {SDA_t, SDA_out, busy}, 3'b110);
        check("t7_ptr", reg_addr, 16'h0000);
        reset = 1'b0;
        i2c_stop;

        check("excl_strobe", n_both, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
